// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute front-end: widths and flag bit positions.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    // Datapath width; the downstream alu is built at this width.
    localparam int WIDTH  = 16;
    // alu opcode field width.
    localparam int OPW    = 3;
    // Register file depth and address width.
    localparam int NREGS  = 8;
    localparam int ADDR_W = $clog2(NREGS);

    // Bit positions inside the packed flags word {N, Z, V, C}.
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam int NFLAGS = 4;

endpackage

// File: rtl/regfile_2r1w.sv
// NREGS x WIDTH register file: two operand read ports, one debug read port, one write port; r0 is hardwired to 0.
// Latency: reads are combinational, the write lands on the next rising clk edge.
// Backpressure: none; the write enable is owned by the caller.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int WIDTH  = alu_pkg::WIDTH,
    parameter int NREGS  = alu_pkg::NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    logic [WIDTH-1:0] mem [NREGS];

    // Storage: async clear of every entry, writes to r0 are dropped so it never holds anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: address 0 always returns zero regardless of storage contents.
    always_comb begin
        rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
        rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
        dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute front-end: operand latch (with forwarding) feeding an external combinational alu, then result/writeback register.
// Latency: accept to out_valid is 2 cycles; one instruction per cycle while out_ready stays high.
// Backpressure: out_ready low holds Stage B, a full Stage A then drops in_ready; nothing is lost, duplicated or reordered.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int NREGS = alu_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // Decoded instruction handshake
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sel,
    input  logic [OPW-1:0]           in_op,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [ADDR_W-1:0]        in_rs1,
    input  logic [ADDR_W-1:0]        in_rs2,
    input  logic                     in_imm_en,
    input  logic [WIDTH-1:0]         in_imm,

    // External combinational alu
    output logic                     alu_select,
    output logic [OPW-1:0]           alu_opcode,
    output logic [WIDTH-1:0]         alu_arg1,
    output logic [WIDTH-1:0]         alu_arg2,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_carry,
    input  logic                     alu_overflow,

    // Result handshake
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_rd,
    output logic [WIDTH-1:0]         out_data,

    // Status flags from the most recent result
    output logic                     flag_c,
    output logic                     flag_v,
    output logic                     flag_z,
    output logic                     flag_n,

    // Register file debug read
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    // Stage A: operands waiting on the alu
    logic                  a_valid;
    logic                  a_sel;
    logic [OPW-1:0]        a_op;
    logic [ADDR_W-1:0]     a_rd;
    logic [WIDTH-1:0]      a_arg1;
    logic [WIDTH-1:0]      a_arg2;

    // Stage B: registered result presented downstream
    logic                  b_valid;
    logic [ADDR_W-1:0]     b_rd;
    logic [WIDTH-1:0]      b_data;
    logic                  b_c;
    logic                  b_v;

    logic [NFLAGS-1:0]     flags_q;

    // Pipeline control
    logic                  b_load;
    logic                  accept;
    logic                  rf_we;

    // Operand paths
    logic [WIDTH-1:0]      rf_rd1;
    logic [WIDTH-1:0]      rf_rd2;
    logic [WIDTH-1:0]      op1_nxt;
    logic [WIDTH-1:0]      op2_nxt;

    // Stage B can take Stage A's result when it is empty or draining this cycle.
    assign b_load   = a_valid && (!b_valid || out_ready);
    // Stage A can take a new instruction when empty or when its current one moves on.
    assign in_ready = !a_valid || b_load;
    assign accept   = in_valid && in_ready;

    // Writeback happens together with the Stage B load; r0 writes are filtered here and in the file.
    assign rf_we    = b_load && (a_rd != '0);

    regfile_2r1w #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (a_rd),
        .wdata    (alu_result),
        .raddr1   (in_rs1),
        .rdata1   (rf_rd1),
        .raddr2   (in_rs2),
        .rdata2   (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Operand select: r0 is zero, a pending Stage A write to the same register is forwarded
    // straight from the alu, otherwise the register file value is used. The immediate overrides rs2.
    always_comb begin
        op1_nxt = rf_rd1;
        if (in_rs1 == '0) begin
            op1_nxt = '0;
        end else if (a_valid && (a_rd == in_rs1)) begin
            op1_nxt = alu_result;
        end

        op2_nxt = rf_rd2;
        if (in_imm_en) begin
            op2_nxt = in_imm;
        end else if (in_rs2 == '0) begin
            op2_nxt = '0;
        end else if (a_valid && (a_rd == in_rs2)) begin
            op2_nxt = alu_result;
        end
    end

    // Stage A: load on accept, empty when its instruction moves to B with nothing behind it, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_sel   <= 1'b0;
            a_op    <= '0;
            a_rd    <= '0;
            a_arg1  <= '0;
            a_arg2  <= '0;
        end else if (accept) begin
            a_valid <= 1'b1;
            a_sel   <= in_sel;
            a_op    <= in_op;
            a_rd    <= in_rd;
            a_arg1  <= op1_nxt;
            a_arg2  <= op2_nxt;
        end else if (b_load) begin
            a_valid <= 1'b0;
        end
    end

    // Stage B: capture the alu outputs on b_load, drop the entry once downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_rd    <= '0;
            b_data  <= '0;
            b_c     <= 1'b0;
            b_v     <= 1'b0;
        end else if (b_load) begin
            b_valid <= 1'b1;
            b_rd    <= a_rd;
            b_data  <= alu_result;
            b_c     <= alu_carry;
            b_v     <= alu_overflow;
        end else if (out_ready) begin
            b_valid <= 1'b0;
        end
    end

    // Flags track every result, including ones whose destination is r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (b_load) begin
            flags_q[FLAG_C] <= alu_carry;
            flags_q[FLAG_V] <= alu_overflow;
            flags_q[FLAG_Z] <= (alu_result == '0);
            flags_q[FLAG_N] <= alu_result[WIDTH-1];
        end
    end

    // The alu sees Stage A directly; it stays stable while A holds, which keeps forwarding valid.
    assign alu_select = a_sel;
    assign alu_opcode = a_op;
    assign alu_arg1   = a_arg1;
    assign alu_arg2   = a_arg2;

    assign out_valid  = b_valid;
    assign out_rd     = b_rd;
    assign out_data   = b_data;

    assign flag_c     = flags_q[FLAG_C];
    assign flag_v     = flags_q[FLAG_V];
    assign flag_z     = flags_q[FLAG_Z];
    assign flag_n     = flags_q[FLAG_N];

    // b_c / b_v mirror the flag word for the presented entry; kept so the result record is complete.
    logic unused_b;
    assign unused_b = b_c ^ b_v;

endmodule

// File: tb/tb_alu_exec_stage.sv
`timescale 1ns/100ps
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sel, in_imm_en;
    logic [2:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [15:0] in_imm;
    logic        alu_select;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_arg1, alu_arg2, alu_result;
    logic        alu_carry, alu_overflow;
    logic        out_valid, out_ready;
    logic [2:0]  out_rd;
    logic [15:0] out_data;
    logic        flag_c, flag_v, flag_z, flag_n;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #10 clk = ~clk;

    // Stub alu: unsigned add, carry out of the top bit, signed add overflow.
    logic [16:0] sum;
    assign sum          = {1'b0, alu_arg1} + {1'b0, alu_arg2};
    assign alu_result   = sum[15:0];
    assign alu_carry    = sum[16];
    assign alu_overflow = (alu_arg1[15] == alu_arg2[15]) && (sum[15] != alu_arg1[15]);

    alu_exec_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_select(alu_select), .alu_opcode(alu_opcode), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
        .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct {
        logic        sel;
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        imm_en;
        logic [15:0] imm;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;   // {N, Z, V, C}
    } vec_t;

    int checks   = 0;
    int failures = 0;

    vec_t vt [10];
    vec_t sv [3];

    function automatic vec_t mk(input logic sel, input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] rs1, input logic [2:0] rs2, input logic imm_en,
                                input logic [15:0] imm, input logic [15:0] exp_data,
                                input logic [3:0] exp_flags);
        vec_t v;
        v.sel = sel; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm_en = imm_en; v.imm = imm; v.exp_data = exp_data; v.exp_flags = exp_flags;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_sel = 1'b0; in_op = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm_en = 1'b0; in_imm = '0;
    endtask

    task automatic drive_instr(input vec_t v);
        in_valid = 1'b1; in_sel = v.sel; in_op = v.op; in_rd = v.rd;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm_en = v.imm_en; in_imm = v.imm;
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_n, flag_z, flag_v, flag_c};
    endfunction

    task automatic chk_dbg(input string name, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        chk(name, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    // Streams sv[0..2]; out_ready held low for the first 'stall' cycles.
    // Inputs change at posedge+1, outputs are sampled at posedge+2.
    task automatic run_stream(input string tag, input int stall,
                              output int acc_in_stall, output int ready_drops,
                              output int first, output int last, output int pops);
        int idx;
        idx = 0; acc_in_stall = 0; ready_drops = 0; first = -1; last = -1; pops = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = (cyc >= stall);
            if (idx < 3) drive_instr(sv[idx]);
            else drive_idle();
            #1;
            if (in_valid && !in_ready) ready_drops++;
            if (out_valid && !out_ready)
                chk({tag, "_hold_data"}, {16'h0, out_data}, {16'h0, sv[0].exp_data});
            if (out_valid && out_ready) begin
                if (pops < 3) begin
                    chk({tag, "_rd"},    {29'h0, out_rd},      {29'h0, sv[pops].rd});
                    chk({tag, "_data"},  {16'h0, out_data},    {16'h0, sv[pops].exp_data});
                    chk({tag, "_flags"}, {28'h0, flags_now()}, {28'h0, sv[pops].exp_flags});
                end
                if (first < 0) first = cyc;
                last = cyc;
                pops++;
            end
            if (in_valid && in_ready) begin
                if (cyc < stall) acc_in_stall++;
                idx++;
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int got, acc, drops, first, last, pops;

        rst_n = 1'b0; out_ready = 1'b1; dbg_addr = '0;
        drive_idle();

        // Vectors run one at a time; register contents carry over between rows.
        vt[0] = mk(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h000F, 16'h000F, 4'b0000);
        vt[1] = mk(1'b1, 3'd1, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFD, 16'hFFFD, 4'b1000);
        vt[2] = mk(1'b0, 3'd2, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h000C, 4'b0001);
        vt[3] = mk(1'b1, 3'd3, 3'd4, 3'd0, 3'd0, 1'b1, 16'h4000, 16'h4000, 4'b0000);
        vt[4] = mk(1'b0, 3'd4, 3'd5, 3'd4, 3'd4, 1'b0, 16'h0000, 16'h8000, 4'b1010);
        vt[5] = mk(1'b1, 3'd5, 3'd6, 3'd0, 3'd0, 1'b1, 16'h8000, 16'h8000, 4'b1000);
        vt[6] = mk(1'b0, 3'd6, 3'd7, 3'd6, 3'd6, 1'b0, 16'h0000, 16'h0000, 4'b0111);
        vt[7] = mk(1'b1, 3'd7, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0007, 16'h0007, 4'b0000);
        vt[8] = mk(1'b0, 3'd1, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0001, 16'h0010, 4'b0000);
        vt[9] = mk(1'b1, 3'd2, 3'd2, 3'd7, 3'd3, 1'b0, 16'hFFFF, 16'h000C, 4'b0000);

        // Reset state
        #3;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
        chk("rst_flags",     {28'h0, flags_now()}, 32'h0);
        chk("rst_out_data",  {16'h0, out_data}, 32'h0);
        @(posedge clk); #5; rst_n = 1'b1;

        // Table-driven single-instruction checks
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive_instr(vt[i]);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
            @(posedge clk); #1;
            drive_idle();
            #1;
            chk($sformatf("v%0d_alu_ctl", i), {28'h0, alu_select, alu_opcode}, {28'h0, vt[i].sel, vt[i].op});
            got = 0;
            for (int n = 0; n < 8 && got == 0; n++) begin
                if (out_valid) got = 1;
                else begin @(posedge clk); #2; end
            end
            chk($sformatf("v%0d_out_valid", i), got, 1);
            if (got == 1) begin
                chk($sformatf("v%0d_rd", i),    {29'h0, out_rd},      {29'h0, vt[i].rd});
                chk($sformatf("v%0d_data", i),  {16'h0, out_data},    {16'h0, vt[i].exp_data});
                chk($sformatf("v%0d_flags", i), {28'h0, flags_now()}, {28'h0, vt[i].exp_flags});
                chk_dbg($sformatf("v%0d_dbg", i), vt[i].rd, (vt[i].rd == 3'd0) ? 16'h0 : vt[i].exp_data);
            end
        end

        // Back-to-back dependent stream with no stall: forward from Stage A, no bubbles
        sv[0] = mk(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h000F, 16'h000F, 4'b0000);
        sv[1] = mk(1'b0, 3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFD, 16'hFFFD, 4'b1000);
        sv[2] = mk(1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h000C, 4'b0001);
        run_stream("s1", 0, acc, drops, first, last, pops);
        chk("s1_ready_drops", drops, 0);
        chk("s1_pops", pops, 3);
        chk("s1_no_bubble", last - first, 2);
        chk_dbg("s1_dbg_r3", 3'd3, 16'h000C);

        // Backpressure: out_ready low for 4 cycles, third instruction depends on the stalled second
        sv[0] = mk(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0001, 16'h0001, 4'b0000);
        sv[1] = mk(1'b0, 3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0002, 16'h0002, 4'b0000);
        sv[2] = mk(1'b0, 3'd0, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0003, 16'h0005, 4'b0000);
        run_stream("s4", 4, acc, drops, first, last, pops);
        chk("s4_accepts_in_stall", acc, 2);
        chk("s4_ready_drops", drops, 2);
        chk("s4_pops", pops, 3);
        chk("s4_first_pop", first, 4);
        chk_dbg("s4_dbg_r1", 3'd1, 16'h0001);
        chk_dbg("s4_dbg_r2", 3'd2, 16'h0002);
        chk_dbg("s4_dbg_r3", 3'd3, 16'h0005);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        @(posedge clk); #1;
        drive_instr(mk(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h8000, 16'h8000, 4'b1000));
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
        drive_instr(mk(1'b0, 3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005, 4'b0000));
        @(posedge clk); #1;
        drive_idle();
        #2;
        chk("s5_pre_out_valid", {31'h0, out_valid}, 32'h1);
        chk("s5_pre_in_ready",  {31'h0, in_ready},  32'h0);
        chk("s5_pre_flag_n",    {31'h0, flag_n},    32'h1);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("s5_rst_in_ready",  {31'h0, in_ready},  32'h1);
        chk("s5_rst_flags",     {28'h0, flags_now()}, 32'h0);
        chk("s5_rst_out_data",  {16'h0, out_data},  32'h0);
        for (int r = 0; r < 8; r++) begin
            chk_dbg($sformatf("s5_rst_r%0d", r), r[2:0], 16'h0);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #2;
            if (out_valid) got++;
        end
        chk("s5_discarded", got, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Two-stage execute front-end that sits directly upstream of the 16-bit alu and consumes its outputs.
- Accepts decoded ALU instructions over a valid/ready handshake and reads operands from an internal 8x16 register file, with forwarding.
- Drives the alu select/opcode/arg ports, then registers the result into the register file and a flags register (C, V, Z, N).
- Presents each result downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width; must match the alu.
- NREGS, 8, register count; address width is log2(NREGS) = 3.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_sel  in  1  alu select bit.
- in_op  in  3  alu opcode.
- in_rd  in  3  destination register.
- in_rs1  in  3  source register 1, feeds arg1.
- in_rs2  in  3  source register 2, feeds arg2 when in_imm_en=0.
- in_imm_en  in  1  use in_imm instead of rs2.
- in_imm  in  WIDTH  immediate operand.
- alu_select  out  1  to alu select.
- alu_opcode  out  3  to alu opcode.
- alu_arg1  out  WIDTH  to alu arg1.
- alu_arg2  out  WIDTH  to alu arg2.
- alu_result  in  WIDTH  from alu.
- alu_carry  in  1  from alu.
- alu_overflow  in  1  from alu.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_rd  out  3  destination of the presented result.
- out_data  out  WIDTH  presented result.
- flag_c  out  1  carry flag.
- flag_v  out  1  overflow flag.
- flag_z  out  1  zero flag.
- flag_n  out  1  negative flag.
- dbg_addr  in  3  register file debug read address.
- dbg_data  out  WIDTH  combinational read of reg[dbg_addr]; reads 0 for address 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_valid, b_valid, out_valid clear to 0.
  - All registers, out_data, out_rd, and all four flags clear to 0.
  - Any in-flight instruction is discarded.
- Stage A (operand latch):
  - Registers a_sel, a_op, a_rd, a_arg1, a_arg2.
  - The alu_* outputs are driven combinationally from these registers.
  - The alu is combinational, so the result is sampled the same cycle.
- Stage B (result register):
  - Registers b_rd, b_data, b_c, b_v.
  - out_valid = b_valid; out_rd = b_rd; out_data = b_data.
- Control signals:
  - b_load = a_valid && (!b_valid || out_ready).
  - in_ready = !a_valid || b_load.
  - accept = in_valid && in_ready.
- On accept:
  - Stage A loads the new instruction; a_valid = 1.
  - Otherwise, if b_load, a_valid = 0.
  - If neither, Stage A holds.
- On b_load:
  - Stage B loads alu_result / alu_carry / alu_overflow; b_valid = 1.
  - Register file writes reg[a_rd] = alu_result unless a_rd = 0.
  - Flags update: C = alu_carry, V = alu_overflow, Z = (alu_result == 0), N = alu_result[WIDTH-1].
  - Flags update even when a_rd = 0.
- When out_valid && out_ready && !b_load, b_valid clears.
- Latency: accept to out_valid is 2 cycles. Throughput is 1 per cycle when out_ready is held high.
- Operand read for arg1 (from rs1) and arg2 (from rs2, or in_imm when in_imm_en = 1), per source:
  - If rs = 0: operand is 0.
  - Else if a_valid && a_rd == rs: forward alu_result, so dependent back-to-back instructions see no bubble.
  - Else: the register file value.
- Stall: while Stage A holds, its ALU inputs are stable, so the forwarded value stays correct.
- Write and read in the same cycle to the same register: the Stage A forward covers it; no read-during-write ambiguity is allowed.
- Backpressure: out_ready low with both stages full drops in_ready to 0. No result or writeback is lost or duplicated, and order is preserved.
- Arithmetic: all values are unsigned WIDTH bits, with no extension. Flag semantics are defined by the alu's carry/overflow outputs.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH and opcode width (3);
  - register address width;
  - flag bit indices (C=0, V=1, Z=2, N=3).
- One sub-module, regfile_2r1w: NREGS x WIDTH, two combinational read ports plus the debug read port, one synchronous write port, asynchronous active-low clear, r0 reads 0.

Test Plan:
- Bench uses a stub alu: result = arg1 + arg2, carry = bit WIDTH, overflow = signed add overflow.
- Scenario 1, immediate load and dependent add:
  - Stimulus: r1 = r0 + imm 15; r2 = r0 + imm 0xFFFD; r3 = r1 + r2, issued back-to-back with out_ready = 1.
  - Response: out_data sequence 15, 65533, 12. Last result has C=1, V=0, Z=0, N=0. No bubbles; in_ready stays 1.
- Scenario 2, signed overflow:
  - Stimulus: r1 = 0x4000 (imm); r2 = r1 + r1.
  - Response: out_data = 0x8000, V=1, N=1, C=0, Z=0.
- Scenario 3, carry to zero:
  - Stimulus: r1 = 0x8000 (imm); r2 = r1 + r1.
  - Response: out_data = 0, C=1, V=1, Z=1, N=0; dbg_data(r2) = 0.
- Scenario 4, backpressure:
  - Stimulus: out_ready = 0 for 4 cycles while 3 instructions are offered.
  - Response: in_ready falls after 2 accepts. Results emerge in order once out_ready = 1, and the register file is checked via dbg.
- Scenario 5, r0 write and asynchronous reset:
  - Stimulus: rd = 0 with imm 7; then pull rst_n low mid-pipeline.
  - Response: out_data = 7 and dbg_data(0) = 0. On reset, out_valid, all flags and all registers read 0 without waiting for a clock edge.
